switch_bank_scanner: RTL and testbench
======================================

Name: switch_bank_scanner

Overview:
- Shared debounce controller for a bank of N panel switches.
- One tick prescaler serves all channels. Each channel has a small settle counter instead of a full 20 ms counter per switch.
- Committed state changes are queued as pending flags, and a round-robin arbiter serialises them into a single valid/ready event stream for the synth control logic (voice/patch select).
- Sits between raw pad inputs and the front-panel command decoder.

Parameters:
- N_SW, 8, number of switch channels (2..32).
- TICK_DIV, 50000, clocks per sample tick (1 ms at 50 MHz).
- SETTLE_TICKS, 20, consecutive disagreeing ticks required to commit a change (≥2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sw_in  in  N_SW  raw asynchronous switch levels
- sw_state  out  N_SW  debounced levels
- ev_valid  out  1  event available
- ev_ready  in  1  consumer accepts event
- ev_index  out  clog2(N_SW)  channel of presented event
- ev_level  out  1  debounced level of that channel at load time
- ev_overrun  out  1  sticky: a channel changed again before its previous change was reported
- ovr_clr  in  1  clears ev_overrun

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) clears the following to 0:
  - synchronizers, prescaler, all settle counters, sw_state, pending flags
  - ev_valid, ev_index, ev_level, ev_overrun
  - round-robin pointer
- Reset mid-operation discards all pending events and any presented event, even if ev_ready=1 in the same cycle.
- Sync: each sw_in bit passes through a 2-flop synchronizer (sync[i]). Detection latency is 2 clks.
- Prescaler:
  - Counts 0..TICK_DIV-1.
  - tick=1 for exactly the cycle where count==TICK_DIV-1, then wraps to 0.
  - First tick is at the TICK_DIV-th clk after reset release.
- Per-channel settle counter, width clog2(SETTLE_TICKS):
  - Any cycle with sync[i]==sw_state[i]: cnt[i]<=0, so a glitch restarts the count.
  - On tick with sync[i]!=sw_state[i]:
    - If cnt[i]==SETTLE_TICKS-1: sw_state[i]<=sync[i], cnt[i]<=0, commit[i]=1.
    - Otherwise cnt[i]<=cnt[i]+1.
  - Non-tick cycles with a disagreement hold cnt.
- Pending flags:
  - commit[i] sets pend[i].
  - If pend[i] is already 1 when commit[i] fires, set ev_overrun. pend stays 1; only one event is reported, carrying the then-current level.
  - Commit and load of the same channel in the same cycle: the set wins, pend[i] stays 1.
- Output register / arbiter:
  - Load condition: (ev_valid==0 or (ev_valid & ev_ready)) and any pend.
  - On load: grant the lowest index ≥ rr_ptr (wrapping), then ev_index<=grant, ev_level<=sw_state[grant], pend[grant]<=0, rr_ptr<=grant+1 mod N_SW, ev_valid<=1.
  - If a handshake occurs and no pend is set, ev_valid<=0.
  - ev_index and ev_level are held stable while ev_valid & !ev_ready.
  - Back-to-back: one event per clk when ev_ready is held high.
- Latency: commit at edge T, so ev_valid=1 after edge T+1 if the output register is empty.
- ev_overrun:
  - Sticky until ovr_clr=1.
  - If ovr_clr and a new overrun occur in the same cycle, ev_overrun=1 (set wins).

Decomposition:
- Package switch_bank_pkg: SW_IDX_W = clog2(N_SW) helper function; default TICK_DIV / SETTLE_TICKS constants; event struct-equivalent field widths.
- One sub-module: rr_pick (N-bit request vector + start pointer → grant index + any_valid, combinational rotate-and-priority-encode).
- Prescaler and per-channel counters stay inline.

Test Plan:
All scenarios use N_SW=8, TICK_DIV=4, SETTLE_TICKS=3, with ev_ready=1 unless stated.
- Clean press: sw_in[2] 0→1 held → sw_state[2]=1 on the 3rd tick after sync; one event {index=2, level=1}; release gives {2, 0}.
- Glitch: sw_in[5] high for 6 clks (spans <3 ticks) → sw_state unchanged, no ev_valid, cnt[5] returns to 0.
- Simultaneous commits on channels 0, 5, 7 with rr_ptr=6 → events ordered 7, 0, 5.
  - With ev_ready=0 for 10 clks, ev_valid stays 1 with index 7 stable.
- Overrun: ch 3 press committed, ev_ready=0; ch 3 released and committed → ev_overrun=1; single event {3, 0} delivered.
  - ovr_clr pulse → ev_overrun=0.
- Reset mid-stream: rst=1 while ev_valid=1 with pends set → next cycle ev_valid=0, sw_state=0, no stale events after release.
- Back-to-back throughput: 8 simultaneous commits with ev_ready=1 → 8 events on 8 consecutive clks, indices 0..7.

Source files
------------

// File: rtl/switch_bank_scanner_pkg.sv
// Shared constants and width helpers for the switch bank scanner.
package switch_bank_pkg;

  localparam int unsigned DefaultNSw         = 8;
  localparam int unsigned DefaultTickDiv     = 50000;
  localparam int unsigned DefaultSettleTicks = 20;

  // Event field widths beyond the channel index.
  localparam int unsigned EvLevelW = 1;

  // Index width for a count of n items; never narrower than one bit.
  function automatic int unsigned sw_idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/switch_bank_scanner_if.sv
// Event stream from the scanner to the front-panel command decoder.
interface switch_bank_scanner_if #(
  parameter int unsigned IdxW = 3
) ();

  logic            ev_valid;
  logic            ev_ready;
  logic [IdxW-1:0] ev_index;
  logic            ev_level;
  logic            ev_overrun;
  logic            ovr_clr;

  modport master (
    output ev_valid, ev_index, ev_level, ev_overrun,
    input  ev_ready, ovr_clr
  );

  modport slave (
    input  ev_valid, ev_index, ev_level, ev_overrun,
    output ev_ready, ovr_clr
  );

endinterface

// File: rtl/switch_bank_scanner_rr_pick.sv
// Round-robin pick: first set request at or after start, wrapping past N-1.
module rr_pick import switch_bank_pkg::*; #(
  parameter int unsigned N    = 8,
  parameter int unsigned IdxW = sw_idx_w(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] start,
  output logic [IdxW-1:0] grant,
  output logic            any_valid
);

  logic [IdxW:0] pos;
  logic          found;

  // Walk the requests in rotated order and keep the first hit.
  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = {1'b0, start} + (IdxW+1)'(k);
      if (pos >= (IdxW+1)'(N)) begin
        pos = pos - (IdxW+1)'(N);
      end
      if (!found && req[pos[IdxW-1:0]]) begin
        found = 1'b1;
        grant = pos[IdxW-1:0];
      end
    end
  end

  assign any_valid = |req;

endmodule

// File: rtl/switch_bank_scanner.sv
// Debounces a bank of switches off one shared tick and serialises the
// committed changes into a single valid/ready event stream.
module switch_bank_scanner import switch_bank_pkg::*; #(
  parameter int unsigned N_SW         = DefaultNSw,
  parameter int unsigned TICK_DIV     = DefaultTickDiv,
  parameter int unsigned SETTLE_TICKS = DefaultSettleTicks
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_SW-1:0]       sw_in,
  output logic [N_SW-1:0]       sw_state,
  switch_bank_scanner_if.master ev
);

  localparam int unsigned IdxW = sw_idx_w(N_SW);
  localparam int unsigned CntW = sw_idx_w(SETTLE_TICKS);
  localparam int unsigned DivW = sw_idx_w(TICK_DIV);

  logic [N_SW-1:0] sync1_q, sync2_q;
  logic [N_SW-1:0] state_q, state_d;
  logic [N_SW-1:0] pend_q, pend_d;
  logic [N_SW-1:0] commit;
  logic [CntW-1:0] cnt_q [N_SW];
  logic [CntW-1:0] cnt_d [N_SW];
  logic [DivW-1:0] div_q;
  logic            tick;

  logic            ev_valid_q, ev_level_q, ev_overrun_q;
  logic [IdxW-1:0] ev_index_q, rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] grant;
  logic            any_pend, hs, load, ovr_set;

  // Two-flop synchroniser on every raw switch input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_in;
      sync2_q <= sync1_q;
    end
  end

  assign tick = (div_q == DivW'(TICK_DIV - 1));

  // Shared sample-tick prescaler.
  always_ff @(posedge clk) begin
    if (rst || tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Settle counters: any agreeing cycle restarts, a tick while disagreeing advances.
  always_comb begin
    state_d = state_q;
    commit  = '0;
    for (int i = 0; i < N_SW; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == state_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CntW'(SETTLE_TICKS - 1)) begin
          state_d[i] = sync2_q[i];
          cnt_d[i]   = '0;
          commit[i]  = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounced state and settle counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      for (int i = 0; i < N_SW; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      for (int i = 0; i < N_SW; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  rr_pick #(
    .N    (N_SW),
    .IdxW (IdxW)
  ) u_rr_pick (
    .req       (pend_q),
    .start     (rr_ptr_q),
    .grant     (grant),
    .any_valid (any_pend)
  );

  // Load/clear decisions for the output register and pending flags.
  always_comb begin
    hs       = ev_valid_q & ev.ev_ready;
    load     = (~ev_valid_q | hs) & any_pend;
    ovr_set  = |(commit & pend_q);
    rr_ptr_d = (grant == IdxW'(N_SW - 1)) ? '0 : grant + 1'b1;
    pend_d   = pend_q;
    if (load) begin
      pend_d[grant] = 1'b0;
    end
    // A commit landing on the channel being loaded keeps it pending.
    pend_d = pend_d | commit;
  end

  // Pending flags, output register, round-robin pointer and sticky overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q       <= '0;
      ev_valid_q   <= 1'b0;
      ev_index_q   <= '0;
      ev_level_q   <= 1'b0;
      ev_overrun_q <= 1'b0;
      rr_ptr_q     <= '0;
    end else begin
      pend_q <= pend_d;
      if (load) begin
        ev_valid_q <= 1'b1;
        ev_index_q <= grant;
        ev_level_q <= state_q[grant];
        rr_ptr_q   <= rr_ptr_d;
      end else if (hs) begin
        ev_valid_q <= 1'b0;
      end
      if (ovr_set) begin
        ev_overrun_q <= 1'b1;
      end else if (ev.ovr_clr) begin
        ev_overrun_q <= 1'b0;
      end
    end
  end

  assign sw_state      = state_q;
  assign ev.ev_valid   = ev_valid_q;
  assign ev.ev_index   = ev_index_q;
  assign ev.ev_level   = ev_level_q;
  assign ev.ev_overrun = ev_overrun_q;

endmodule

// File: tb/tb_switch_bank_scanner.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// cycle by cycle against a behavioural model of the debounce/queue rules.
module tb_switch_bank_scanner;
  import switch_bank_pkg::*;

  localparam int unsigned N    = 8;
  localparam int unsigned TD   = 4;
  localparam int unsigned ST   = 3;
  localparam int unsigned IdxW = sw_idx_w(N);

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] sw_in;
  logic [N-1:0] sw_state;

  switch_bank_scanner_if #(.IdxW(IdxW)) bus ();

  switch_bank_scanner #(
    .N_SW         (N),
    .TICK_DIV     (TD),
    .SETTLE_TICKS (ST)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw_in    (sw_in),
    .sw_state (sw_state),
    .ev       (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state.
  logic [N-1:0] m_s1, m_s2, m_state, m_pend;
  int           m_div;
  int           m_dis [N];  // disagreeing ticks seen so far per channel
  int           m_ptr;
  int           m_index;
  logic         m_valid, m_level, m_ovr;

  typedef struct {
    int idx;
    int lvl;
    int cyc;
  } ev_t;
  ev_t ev_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_state = '0; m_pend = '0;
    m_div = 0; m_ptr = 0; m_index = 0;
    m_valid = 1'b0; m_level = 1'b0; m_ovr = 1'b0;
    for (int i = 0; i < N; i++) m_dis[i] = 0;
  endtask

  // One clock of the debounce/queue rules, evaluated from pre-edge values.
  task automatic model_step();
    logic         tick;
    logic [N-1:0] commit, old_pend, new_state;
    bit           hs;
    int           g;
    if (rst) begin
      model_clear();
      return;
    end
    tick  = (m_div == TD - 1);
    m_div = tick ? 0 : m_div + 1;
    commit    = '0;
    new_state = m_state;
    for (int i = 0; i < N; i++) begin
      if (m_s2[i] == m_state[i]) begin
        m_dis[i] = 0;
      end else if (tick) begin
        m_dis[i]++;
        if (m_dis[i] == ST) begin
          commit[i]    = 1'b1;
          new_state[i] = m_s2[i];
          m_dis[i]     = 0;
        end
      end
    end
    old_pend = m_pend;
    hs = m_valid && bus.ev_ready;
    if ((!m_valid || hs) && old_pend != '0) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        if (g < 0 && old_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      m_index   = g;
      m_level   = m_state[g];
      m_pend[g] = 1'b0;
      m_ptr     = (g + 1) % N;
      m_valid   = 1'b1;
    end else if (hs) begin
      m_valid = 1'b0;
    end
    if (bus.ovr_clr) m_ovr = 1'b0;
    if ((commit & old_pend) != '0) m_ovr = 1'b1;
    m_pend  = m_pend | commit;
    m_state = new_state;
    m_s2    = m_s1;
    m_s1    = sw_in;
  endtask

  task automatic step();
    if (!rst && bus.ev_valid && bus.ev_ready) begin
      ev_q.push_back('{idx: int'(bus.ev_index), lvl: int'(bus.ev_level), cyc: cyc});
    end
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    check("sw_state", sw_state, m_state);
    check("ev_valid", bus.ev_valid, m_valid);
    check("ev_overrun", bus.ev_overrun, m_ovr);
    if (m_valid) begin
      check("ev_index", bus.ev_index, m_index);
      check("ev_level", bus.ev_level, m_level);
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_valid(input string tag, input int limit);
    int k = 0;
    while (!bus.ev_valid && k < limit) begin
      step();
      k++;
    end
    check(tag, bus.ev_valid, 1);
  endtask

  task automatic check_ev(input string tag, input int k, input int idx, input int lvl);
    if (k < ev_q.size()) begin
      check({tag, "_idx"}, ev_q[k].idx, idx);
      check({tag, "_lvl"}, ev_q[k].lvl, lvl);
    end else begin
      check({tag, "_missing"}, ev_q.size(), k + 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int b;
    model_clear();
    rst = 1'b1; sw_in = '0; bus.ev_ready = 1'b1; bus.ovr_clr = 1'b0;
    run(3);
    check("reset_state", sw_state, 0);
    check("reset_valid", bus.ev_valid, 0);
    check("reset_ovr", bus.ev_overrun, 0);
    rst = 1'b0;

    // Clean press and release of channel 2.
    ev_q.delete();
    sw_in = 8'h04; run(24);
    check("press_cnt", ev_q.size(), 1);
    check_ev("press", 0, 2, 1);
    check("press_state", sw_state, 8'h04);
    ev_q.delete();
    sw_in = 8'h00; run(24);
    check("release_cnt", ev_q.size(), 1);
    check_ev("release", 0, 2, 0);

    // Glitch on channel 5 spans fewer than SETTLE_TICKS ticks.
    ev_q.delete();
    sw_in = 8'h20; run(6);
    sw_in = 8'h00; run(24);
    check("glitch_cnt", ev_q.size(), 0);
    check("glitch_state", sw_state, 0);
    check("glitch_settle", dut.cnt_q[5], 0);

    // Channel 5 event leaves rr_ptr at 6; then 0,5,7 commit together.
    sw_in = 8'h20; run(24);
    bus.ev_ready = 1'b0;
    sw_in = 8'h81;
    wait_valid("rr_wait", 40);
    for (int k = 0; k < 10; k++) begin
      check("rr_hold_valid", bus.ev_valid, 1);
      check("rr_hold_idx", bus.ev_index, 7);
      step();
    end
    ev_q.delete();
    bus.ev_ready = 1'b1; run(8);
    check("rr_cnt", ev_q.size(), 3);
    check_ev("rr0", 0, 7, 1);
    check_ev("rr1", 1, 0, 1);
    check_ev("rr2", 2, 5, 0);

    // Overrun: channel 1 holds the output, channel 3 commits twice meanwhile.
    bus.ev_ready = 1'b0;
    sw_in = 8'h83; run(24);
    sw_in = 8'h8b; run(24);
    check("ovr_before", bus.ev_overrun, 0);
    sw_in = 8'h83; run(24);
    check("ovr_set", bus.ev_overrun, 1);
    ev_q.delete();
    bus.ev_ready = 1'b1; run(6);
    check("ovr_cnt", ev_q.size(), 2);
    check_ev("ovr0", 0, 1, 1);
    check_ev("ovr1", 1, 3, 0);
    check("ovr_sticky", bus.ev_overrun, 1);
    bus.ovr_clr = 1'b1; step();
    bus.ovr_clr = 1'b0;
    check("ovr_clr", bus.ev_overrun, 0);

    // Reset while an event is presented and more are pending.
    bus.ev_ready = 1'b0;
    sw_in = 8'h00;
    wait_valid("rst_wait", 40);
    run(2);
    bus.ev_ready = 1'b1; rst = 1'b1; step();
    check("rst_valid", bus.ev_valid, 0);
    check("rst_state", sw_state, 0);
    rst = 1'b0;
    ev_q.delete();
    run(30);
    check("rst_stale", ev_q.size(), 0);

    // Eight simultaneous commits drain on consecutive clocks.
    sw_in = 8'hff; run(30);
    check("b2b_cnt", ev_q.size(), 8);
    for (int k = 0; k < 8; k++) begin
      check_ev("b2b", k, k, 1);
      if (k < ev_q.size()) check("b2b_cyc", ev_q[k].cyc - ev_q[0].cyc, k);
    end

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        b = $urandom_range(0, N - 1);
        sw_in[b] = ~sw_in[b];
      end
      bus.ev_ready = ($urandom_range(0, 3) != 0);
      bus.ovr_clr  = ($urandom_range(0, 31) == 0);
      rst          = ($urandom_range(0, 599) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
